// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory handshakes.
// Optional byte/halfword loads and stores are enabled by defining CTRL_BYTE_HALF_EN.
module multicycle_control #(
   parameter int W           = 6,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] opcode_in,
   input  logic [W-1:0] funct_in,
   input  logic         alu_zero,
   input  logic         imem_ready,
   input  logic         dmem_ready,
   output logic [2:0]   state,
   output logic         imem_req,
   output logic         ir_load,
   output logic         pc_write,
   output logic [1:0]   pc_src,
   output logic [W-1:0] alu_function,
   output logic         uses_immediate_in_alu,
   output logic         is_signed,
   output logic         is_lui,
   output logic         is_link,
   output logic         is_jump_reg,
   output logic         datamem_read_enable,
   output logic         datamem_write_enable,
   output logic [1:0]   word_size,
   output logic         load_signed,
   output logic         reads_memory,
   output logic         reg_write_enabled,
   output logic         instr_retired,
   output logic [1:0]   error_code
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DEC   = 3'd2,
      S_EXE   = 3'd3,
      S_MEM   = 3'd4,
      S_WB    = 3'd5,
      S_ERR   = 3'd7
   } st_t;

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW:0] TMO_LIM = (CW + 1)'(MEM_TIMEOUT);

   localparam logic [W-1:0] ALU_ADD = W'('h20);
   localparam logic [W-1:0] ALU_SUB = W'('h22);
   localparam logic [W-1:0] ALU_AND = W'('h24);
   localparam logic [W-1:0] ALU_OR  = W'('h25);
   localparam logic [W-1:0] ALU_XOR = W'('h26);
   localparam logic [W-1:0] ALU_FJ  = W'('h3A);

   st_t           st;
   logic [CW-1:0] cnt;
   logic [CW:0]   cnt_nx;
   logic          tmo;

   logic          r_ld, r_st, r_beq, r_bne, r_wb;

   logic [5:0]    op, fn;
   logic          op_hi, fn_hi;
   logic [W-1:0]  d_alu;
   logic [1:0]    d_ws;
   logic          d_imm, d_sgn, d_lui, d_link, d_jr, d_jmp;
   logic          d_ld, d_st, d_lsg, d_beq, d_bne, d_wb, d_ill;

   assign state  = st;
   assign op     = opcode_in[5:0];
   assign fn     = funct_in[5:0];
   assign op_hi  = (opcode_in >> 6) != '0;
   assign fn_hi  = (funct_in >> 6) != '0;
   assign cnt_nx = {1'b0, cnt} + 1'b1;
   // A wait cycle that would bring the count to the limit is a timeout.
   assign tmo    = (MEM_TIMEOUT != 0) && (cnt_nx == TMO_LIM);

   // Decode the IR fields into the control set latched at the end of DECODE.
   always_comb begin
      d_alu  = '0;
      d_ws   = 2'b11;
      d_imm  = 1'b0;
      d_sgn  = 1'b1;
      d_lui  = 1'b0;
      d_link = 1'b0;
      d_jr   = 1'b0;
      d_jmp  = 1'b0;
      d_ld   = 1'b0;
      d_st   = 1'b0;
      d_lsg  = 1'b0;
      d_beq  = 1'b0;
      d_bne  = 1'b0;
      d_wb   = 1'b0;
      d_ill  = 1'b0;
      if (op_hi) begin
         d_ill = 1'b1;
      end else begin
         case (op)
            6'h00: begin
               d_alu = funct_in;
               d_ill = fn_hi;
               if (fn == 6'h08) begin
                  d_jr = 1'b1;
               end else if (fn == 6'h09) begin
                  d_jr   = 1'b1;
                  d_link = 1'b1;
                  d_wb   = 1'b1;
               end else begin
                  d_wb = 1'b1;
               end
            end
            6'h02: begin
               d_alu = ALU_FJ;
               d_jmp = 1'b1;
            end
            6'h03: begin
               d_alu  = ALU_FJ;
               d_jmp  = 1'b1;
               d_link = 1'b1;
               d_wb   = 1'b1;
            end
            6'h04: begin
               d_alu = ALU_SUB;
               d_beq = 1'b1;
            end
            6'h05: begin
               d_alu = ALU_SUB;
               d_bne = 1'b1;
            end
            6'h08, 6'h09: begin
               d_alu = ALU_ADD;
               d_imm = 1'b1;
               d_wb  = 1'b1;
            end
            6'h0C: begin
               d_alu = ALU_AND;
               d_imm = 1'b1;
               d_sgn = 1'b0;
               d_wb  = 1'b1;
            end
            6'h0D: begin
               d_alu = ALU_OR;
               d_imm = 1'b1;
               d_sgn = 1'b0;
               d_wb  = 1'b1;
            end
            6'h0E: begin
               d_alu = ALU_XOR;
               d_imm = 1'b1;
               d_sgn = 1'b0;
               d_wb  = 1'b1;
            end
            6'h0F: begin
               d_alu = ALU_ADD;
               d_imm = 1'b1;
               d_lui = 1'b1;
               d_wb  = 1'b1;
            end
            6'h23: begin
               d_alu = ALU_ADD;
               d_imm = 1'b1;
               d_ld  = 1'b1;
            end
            6'h2B: begin
               d_alu = ALU_ADD;
               d_imm = 1'b1;
               d_st  = 1'b1;
            end
`ifdef CTRL_BYTE_HALF_EN
            6'h20, 6'h21, 6'h24, 6'h25: begin
               d_alu = ALU_ADD;
               d_imm = 1'b1;
               d_ld  = 1'b1;
               d_ws  = op[0] ? 2'b01 : 2'b00;
               d_lsg = ~op[2];
            end
            6'h28, 6'h29: begin
               d_alu = ALU_ADD;
               d_imm = 1'b1;
               d_st  = 1'b1;
               d_ws  = op[0] ? 2'b01 : 2'b00;
            end
`endif
            default: d_ill = 1'b1;
         endcase
      end
   end

   // Sequencer: state, wait counter and every registered control output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st                    <= S_IDLE;
         cnt                   <= '0;
         imem_req              <= 1'b0;
         ir_load               <= 1'b0;
         pc_write              <= 1'b0;
         pc_src                <= 2'b00;
         alu_function          <= '0;
         uses_immediate_in_alu <= 1'b0;
         is_signed             <= 1'b1;
         is_lui                <= 1'b0;
         is_link               <= 1'b0;
         is_jump_reg           <= 1'b0;
         datamem_read_enable   <= 1'b0;
         datamem_write_enable  <= 1'b0;
         word_size             <= 2'b11;
         load_signed           <= 1'b0;
         reads_memory          <= 1'b0;
         reg_write_enabled     <= 1'b0;
         instr_retired         <= 1'b0;
         error_code            <= 2'b00;
         r_ld                  <= 1'b0;
         r_st                  <= 1'b0;
         r_beq                 <= 1'b0;
         r_bne                 <= 1'b0;
         r_wb                  <= 1'b0;
      end else begin
         ir_load           <= 1'b0;
         pc_write          <= 1'b0;
         reg_write_enabled <= 1'b0;
         instr_retired     <= 1'b0;
         cnt               <= '0;
         case (st)
            S_IDLE: begin
               st       <= S_FETCH;
               imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  imem_req <= 1'b0;
                  ir_load  <= 1'b1;
                  pc_write <= 1'b1;
                  pc_src   <= 2'b00;
                  st       <= S_DEC;
               end else if (tmo) begin
                  imem_req   <= 1'b0;
                  error_code <= 2'b10;
                  st         <= S_ERR;
               end else begin
                  cnt <= cnt_nx[CW-1:0];
               end
            end
            S_DEC: begin
               if (d_ill) begin
                  error_code <= 2'b01;
                  st         <= S_ERR;
               end else begin
                  alu_function          <= d_alu;
                  uses_immediate_in_alu <= d_imm;
                  is_signed             <= d_sgn;
                  is_lui                <= d_lui;
                  is_link               <= d_link;
                  is_jump_reg           <= d_jr;
                  word_size             <= d_ws;
                  load_signed           <= d_lsg;
                  reads_memory          <= d_ld;
                  r_ld                  <= d_ld;
                  r_st                  <= d_st;
                  r_beq                 <= d_beq;
                  r_bne                 <= d_bne;
                  r_wb                  <= d_wb;
                  // Unconditional jumps redirect the PC during EXECUTE.
                  if (d_jmp) begin
                     pc_write <= 1'b1;
                     pc_src   <= 2'b10;
                  end else if (d_jr) begin
                     pc_write <= 1'b1;
                     pc_src   <= 2'b11;
                  end
                  st <= S_EXE;
               end
            end
            S_EXE: begin
               if (r_ld || r_st) begin
                  datamem_read_enable  <= r_ld;
                  datamem_write_enable <= r_st;
                  st                   <= S_MEM;
               end else if (r_wb) begin
                  reg_write_enabled <= 1'b1;
                  instr_retired     <= 1'b1;
                  st                <= S_WB;
               end else begin
                  // alu_zero is only valid at the end of EXECUTE.
                  if ((r_beq && alu_zero) || (r_bne && !alu_zero)) begin
                     pc_write <= 1'b1;
                     pc_src   <= 2'b01;
                  end
                  instr_retired <= 1'b1;
                  imem_req      <= 1'b1;
                  st            <= S_FETCH;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  datamem_read_enable  <= 1'b0;
                  datamem_write_enable <= 1'b0;
                  instr_retired        <= 1'b1;
                  if (r_ld) begin
                     reg_write_enabled <= 1'b1;
                     st                <= S_WB;
                  end else begin
                     imem_req <= 1'b1;
                     st       <= S_FETCH;
                  end
               end else if (tmo) begin
                  datamem_read_enable  <= 1'b0;
                  datamem_write_enable <= 1'b0;
                  error_code           <= 2'b11;
                  st                   <= S_ERR;
               end else begin
                  cnt <= cnt_nx[CW-1:0];
               end
            end
            S_WB: begin
               imem_req <= 1'b1;
               st       <= S_FETCH;
            end
            S_ERR: begin
               st <= S_ERR;
            end
            default: begin
               st <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed sequence of fetches, executes and memory accesses.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode_in, funct_in;
   logic       alu_zero, imem_ready, dmem_ready;
   logic [2:0] state;
   logic       imem_req, ir_load, pc_write;
   logic [1:0] pc_src;
   logic [5:0] alu_function;
   logic       uses_immediate_in_alu, is_signed, is_lui, is_link, is_jump_reg;
   logic       datamem_read_enable, datamem_write_enable;
   logic [1:0] word_size;
   logic       load_signed, reads_memory, reg_write_enabled, instr_retired;
   logic [1:0] error_code;

   int checks = 0;
   int errors = 0;

   multicycle_control #(.W(6), .MEM_TIMEOUT(15)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .opcode_in(opcode_in),
      .funct_in(funct_in),
      .alu_zero(alu_zero),
      .imem_ready(imem_ready),
      .dmem_ready(dmem_ready),
      .state(state),
      .imem_req(imem_req),
      .ir_load(ir_load),
      .pc_write(pc_write),
      .pc_src(pc_src),
      .alu_function(alu_function),
      .uses_immediate_in_alu(uses_immediate_in_alu),
      .is_signed(is_signed),
      .is_lui(is_lui),
      .is_link(is_link),
      .is_jump_reg(is_jump_reg),
      .datamem_read_enable(datamem_read_enable),
      .datamem_write_enable(datamem_write_enable),
      .word_size(word_size),
      .load_signed(load_signed),
      .reads_memory(reads_memory),
      .reg_write_enabled(reg_write_enabled),
      .instr_retired(instr_retired),
      .error_code(error_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Starts at the first FETCH cycle, ends at the DECODE cycle.
   task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn, input int waits);
      opcode_in  = op;
      funct_in   = fn;
      imem_ready = 1'b0;
      repeat (waits) tick();
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
   endtask

   // Resets and ends at the first FETCH cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_state", {5'd0, state}, 8'd0);
      tick();
   endtask

   initial begin
      rst_n      = 1'b0;
      opcode_in  = '0;
      funct_in   = '0;
      alu_zero   = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      tick();
      tick();
      chk("rst_st", {5'd0, state}, 8'd0);
      chk("rst_ws", {6'd0, word_size}, 8'd3);
      chk("rst_sgn", {7'd0, is_signed}, 8'd1);
      chk("rst_req", {7'd0, imem_req}, 8'd0);
      chk("rst_err", {6'd0, error_code}, 8'd0);
      chk("rst_ret", {7'd0, instr_retired}, 8'd0);
      rst_n = 1'b1;
      tick();

      // ADDI with two imem wait states
      chk("f_st", {5'd0, state}, 8'd1);
      chk("f_req", {7'd0, imem_req}, 8'd1);
      do_fetch(6'h08, 6'h00, 2);
      chk("addi_dec", {5'd0, state}, 8'd2);
      chk("addi_irl", {7'd0, ir_load}, 8'd1);
      chk("addi_pcw", {7'd0, pc_write}, 8'd1);
      chk("addi_pcs", {6'd0, pc_src}, 8'd0);
      chk("addi_req", {7'd0, imem_req}, 8'd0);
      tick();
      chk("addi_exe", {5'd0, state}, 8'd3);
      chk("addi_alu", {2'd0, alu_function}, 8'h20);
      chk("addi_imm", {7'd0, uses_immediate_in_alu}, 8'd1);
      chk("addi_irl0", {7'd0, ir_load}, 8'd0);
      chk("addi_rw0", {7'd0, reg_write_enabled}, 8'd0);
      tick();
      chk("addi_wb", {5'd0, state}, 8'd5);
      chk("addi_rw", {7'd0, reg_write_enabled}, 8'd1);
      chk("addi_ret", {7'd0, instr_retired}, 8'd1);
      tick();
      chk("addi_f", {5'd0, state}, 8'd1);
      chk("addi_rw1", {7'd0, reg_write_enabled}, 8'd0);
      chk("addi_ret1", {7'd0, instr_retired}, 8'd0);

      // LW with three dmem wait states
      do_fetch(6'h23, 6'h00, 0);
      tick();
      chk("lw_ws", {6'd0, word_size}, 8'd3);
      chk("lw_ls", {7'd0, load_signed}, 8'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("lw_mst", {5'd0, state}, 8'd4);
         chk("lw_rde", {7'd0, datamem_read_enable}, 8'd1);
         if (i == 3) dmem_ready = 1'b1;
         tick();
      end
      dmem_ready = 1'b0;
      chk("lw_wb", {5'd0, state}, 8'd5);
      chk("lw_rde0", {7'd0, datamem_read_enable}, 8'd0);
      chk("lw_rdm", {7'd0, reads_memory}, 8'd1);
      chk("lw_rw", {7'd0, reg_write_enabled}, 8'd1);
      chk("lw_ret", {7'd0, instr_retired}, 8'd1);
      tick();

      // BEQ taken
      do_fetch(6'h04, 6'h00, 0);
      tick();
      chk("beq_alu", {2'd0, alu_function}, 8'h22);
      chk("beq_pcw0", {7'd0, pc_write}, 8'd0);
      alu_zero = 1'b1;
      tick();
      chk("beq_st", {5'd0, state}, 8'd1);
      chk("beq_pcw", {7'd0, pc_write}, 8'd1);
      chk("beq_pcs", {6'd0, pc_src}, 8'd1);
      chk("beq_ret", {7'd0, instr_retired}, 8'd1);

      // BNE not taken
      do_fetch(6'h05, 6'h00, 0);
      tick();
      tick();
      chk("bne_st", {5'd0, state}, 8'd1);
      chk("bne_pcw", {7'd0, pc_write}, 8'd0);
      chk("bne_ret", {7'd0, instr_retired}, 8'd1);
      alu_zero = 1'b0;

      // J
      do_fetch(6'h02, 6'h00, 0);
      tick();
      chk("j_pcw", {7'd0, pc_write}, 8'd1);
      chk("j_pcs", {6'd0, pc_src}, 8'd2);
      tick();
      chk("j_st", {5'd0, state}, 8'd1);
      chk("j_ret", {7'd0, instr_retired}, 8'd1);
      chk("j_pcw0", {7'd0, pc_write}, 8'd0);

      // JALR
      do_fetch(6'h00, 6'h09, 0);
      tick();
      chk("jalr_pcs", {6'd0, pc_src}, 8'd3);
      chk("jalr_jr", {7'd0, is_jump_reg}, 8'd1);
      chk("jalr_lnk", {7'd0, is_link}, 8'd1);
      tick();
      chk("jalr_wb", {5'd0, state}, 8'd5);
      tick();

      // ORI zero-extends
      do_fetch(6'h0D, 6'h00, 0);
      tick();
      chk("ori_alu", {2'd0, alu_function}, 8'h25);
      chk("ori_sgn", {7'd0, is_signed}, 8'd0);
      tick();
      tick();

      // SW acked on the 15th MEMORY cycle
      do_fetch(6'h2B, 6'h00, 0);
      tick();
      tick();
      for (int i = 0; i < 15; i++) begin
         if (i == 14) dmem_ready = 1'b1;
         tick();
      end
      dmem_ready = 1'b0;
      chk("sw15_st", {5'd0, state}, 8'd1);
      chk("sw15_err", {6'd0, error_code}, 8'd0);
      chk("sw15_ret", {7'd0, instr_retired}, 8'd1);
      chk("sw15_wre", {7'd0, datamem_write_enable}, 8'd0);

      // Async reset in the middle of a store
      do_fetch(6'h2B, 6'h00, 0);
      tick();
      tick();
      chk("swr_wre1", {7'd0, datamem_write_enable}, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("swr_wre0", {7'd0, datamem_write_enable}, 8'd0);
      chk("swr_st0", {5'd0, state}, 8'd0);
      tick();
      rst_n = 1'b1;
      chk("swr_idle", {5'd0, state}, 8'd0);
      tick();
      chk("swr_fetch", {5'd0, state}, 8'd1);

      // Illegal opcode
      do_fetch(6'h3F, 6'h00, 0);
      tick();
      chk("ill_st", {5'd0, state}, 8'd7);
      chk("ill_err", {6'd0, error_code}, 8'd1);
      tick();
      tick();
      tick();
      chk("ill_hold", {5'd0, state}, 8'd7);
      chk("ill_errh", {6'd0, error_code}, 8'd1);
      chk("ill_req", {7'd0, imem_req}, 8'd0);

      // Instruction fetch timeout
      do_reset();
      imem_ready = 1'b0;
      repeat (14) tick();
      chk("itmo_pre", {5'd0, state}, 8'd1);
      chk("itmo_req", {7'd0, imem_req}, 8'd1);
      tick();
      chk("itmo_st", {5'd0, state}, 8'd7);
      chk("itmo_err", {6'd0, error_code}, 8'd2);
      chk("itmo_req0", {7'd0, imem_req}, 8'd0);

      // LBU depends on the build
      do_reset();
      do_fetch(6'h24, 6'h00, 0);
      tick();
`ifdef CTRL_BYTE_HALF_EN
      chk("lbu_st", {5'd0, state}, 8'd3);
      chk("lbu_ws", {6'd0, word_size}, 8'd0);
      chk("lbu_ls", {7'd0, load_signed}, 8'd0);
`else
      chk("lbu_st", {5'd0, state}, 8'd7);
      chk("lbu_err", {6'd0, error_code}, 8'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
